// File: rtl/dmem_responder.sv
// Data-memory responder: RV32I sized load/store over valid/ready.
// Build option DMEM_MISALIGN_ERR_EN flags misaligned half/word accesses.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS_LAST =
    4'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_t;

  typedef struct packed {
    logic          we;
    logic [AW+1:0] addr;
    logic [31:0]   wdata;
    logic [2:0]    f3;
  } req_t;

  state_t state, state_nx;
  req_t   q;
  logic [3:0]  cnt;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic [AW-1:0] idx;
  logic [31:0]   word;
  logic [1:0]    lane;
  logic          is_b, is_h, is_w, is_u;
  logic          f3_ok, mis, err_c;
  logic [7:0]    ld_b;
  logic [15:0]   ld_h;
  logic [31:0]   ld_val;
  logic [3:0]    wmask;
  logic [31:0]   wpat, wmerged;
  logic          wr_en;
  logic          unused_addr;

  assign unused_addr = ^req_addr[31:AW+2];

  assign accept     = req_valid && state == S_IDLE;
  assign req_ready  = state == S_IDLE;
  assign busy       = state != S_IDLE;
  assign resp_valid = state == S_RESP;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (req_valid)
          state_nx = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
      end
      S_WAIT: begin
        if (cnt == WS_LAST) state_nx = S_ACCESS;
      end
      S_ACCESS: state_nx = S_RESP;
      S_RESP: begin
        if (resp_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Size/sign decode of the latched request
  assign is_b = q.f3[1:0] == 2'b00;
  assign is_h = q.f3[1:0] == 2'b01;
  assign is_w = q.f3 == 3'b010;
  assign is_u = q.f3[2];

  always_comb begin
    f3_ok = 1'b0;
    if (q.we) f3_ok = q.f3 inside {3'b000, 3'b001, 3'b010};
    else      f3_ok = q.f3 inside {3'b000, 3'b001, 3'b010,
                                   3'b100, 3'b101};
  end

`ifdef DMEM_MISALIGN_ERR_EN
  assign mis  = (is_h && q.addr[0]) || (is_w && |q.addr[1:0]);
  assign lane = q.addr[1:0];
`else
  assign mis  = 1'b0;
  // Misaligned halves/words snap down to their natural boundary
  assign lane = is_w ? 2'b00 :
                is_h ? {q.addr[1], 1'b0} : q.addr[1:0];
`endif

  assign err_c = !f3_ok || mis;
  assign idx   = q.addr[AW+1:2];
  assign word  = mem[idx];
  assign ld_b  = word[{lane, 3'b000} +: 8];
  assign ld_h  = lane[1] ? word[31:16] : word[15:0];

  always_comb begin
    ld_val = word;
    unique case (1'b1)
      is_b:    ld_val = {{24{!is_u && ld_b[7]}}, ld_b};
      is_h:    ld_val = {{16{!is_u && ld_h[15]}}, ld_h};
      default: ld_val = word;
    endcase
  end

  always_comb begin
    wmask = 4'b1111;
    wpat  = q.wdata;
    unique case (1'b1)
      is_b: begin
        wmask = 4'b0001 << lane;
        wpat  = {4{q.wdata[7:0]}};
      end
      is_h: begin
        wmask = lane[1] ? 4'b1100 : 4'b0011;
        wpat  = {2{q.wdata[15:0]}};
      end
      default: begin
        wmask = 4'b1111;
        wpat  = q.wdata;
      end
    endcase
  end

  always_comb begin
    wmerged = word;
    for (int i = 0; i < 4; i++)
      if (wmask[i]) wmerged[i*8 +: 8] = wpat[i*8 +: 8];
  end

  assign wr_en = state == S_ACCESS && q.we && !err_c;

  always_ff @(posedge clk) begin
    if (wr_en) mem[idx] <= wmerged;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q       <= '0;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        q.we    <= req_we;
        q.addr  <= req_addr[AW+1:0];
        q.wdata <= req_wdata;
        q.f3    <= req_funct3;
        cnt     <= '0;
      end
      if (state == S_WAIT) cnt <= cnt + 4'd1;
      if (state == S_ACCESS) begin
        err_q   <= err_c;
        rdata_q <= (err_c || q.we) ? 32'h0 : ld_val;
      end
      if (state == S_RESP && resp_ready) begin
        err_q   <= 1'b0;
        rdata_q <= '0;
      end
    end
  end

endmodule
